ddr_cache_interface: RTL and testbench
======================================

# ddr_cache_interface

Sits between `data_cache` and the DDR burst controller. Arbitrates the cache's three request levels: data load, data store and jump-address load. Converts each granted request into one read or write burst on the controller's burst port. Returns beat data, beat counts and write-data requests to the cache with the exact numbering and state codes the cache decodes.

## Interface
Parameters:
- `DATA_WIDTH`, 16, cache word / DDR beat width
- `DATA_CACHE_DEPTH`, 16, words per data burst (read and write)
- `DDR_ADDR_WIDTH`, 28, DDR byte address width

Ports:
- `clk`  in  1  single system clock
- `rst`  in  1  reset, asynchronous, active-low
- `DATA_read_req`, `DATA_store_req`, `JMP_ADDR_read_req`  in  1 each  request levels from cache
- `DATA_read_addr`, `DATA_write_addr`  in  DDR_ADDR_WIDTH  burst start addresses (already ×8)
- `DATA_to_ddr`  in  DATA_WIDTH  store word from cache
- `DATA_to_cache`  out  DATA_WIDTH  read beat to cache
- `JMP_ADDR_to_cache`  out  DDR_ADDR_WIDTH  zero-extended jump-read beat
- `rd_cnt_data`  out  10  read beat number
- `rd_burst_data_valid`  out  1  beat valid to cache
- `wr_burst_data_req`  out  1  write-beat request to cache
- `state_interface_module`  out  4  current state code
- `rd_burst_req`, `wr_burst_req`  out  1  burst requests to controller
- `rd_burst_len`, `wr_burst_len`  out  10  beats per burst
- `rd_burst_addr`, `wr_burst_addr`  out  DDR_ADDR_WIDTH  burst addresses
- `rd_burst_data_valid_in`  in  1  controller read beat valid
- `rd_burst_data_in`  in  DATA_WIDTH  controller read beat
- `rd_burst_finish`, `wr_burst_finish`  in  1  controller end-of-burst pulse
- `wr_burst_data_req_in`  in  1  controller requests next write beat
- `wr_burst_data_out`  out  DATA_WIDTH  write beat to controller

## Operation
- States and codes:
  - IDLE=0
  - MEM_READ_DATA=2
  - MEM_READ_JMP=3
  - MEM_WAIT_RELEASE=8
  - MEM_WRITE_DATA_STORE=9
- Reset: all outputs 0, state IDLE.
- IDLE: samples the request levels. Priority is store > data read > jump read.
- On grant:
  - Latch the address into `rd_burst_addr` / `wr_burst_addr`.
  - Latch the length: DATA_CACHE_DEPTH for data bursts, 1 for jump reads.
  - Assert `rd_burst_req` / `wr_burst_req` and move to the granted state.
- Burst requests stay high until the matching `*_finish` pulse.
- Read counter:
  - `rd_cnt_data` is preloaded at grant to 1 for data reads and 0 for jump reads.
  - It increments on every `rd_burst_data_valid_in` beat.
  - It is held after the burst and cleared only at the next grant.
  - Beat k of a data read therefore carries k+2. Beat 0 of a jump read carries 1.
- Read data path, both registered:
  - `DATA_to_cache` ← `rd_burst_data_in`
  - `rd_burst_data_valid` ← `rd_burst_data_valid_in`
- Jump read: `JMP_ADDR_to_cache` latches zero-extended `rd_burst_data_in` on the valid beat and holds until the next jump grant.
- Write path:
  - `wr_burst_data_req` = `wr_burst_data_req_in` when state is MEM_WRITE_DATA_STORE, else 0.
  - `wr_burst_data_out` = `DATA_to_ddr`, combinational pass-through.
- End of burst:
  - On `*_finish`, deassert the burst request and go to MEM_WAIT_RELEASE.
  - Leave MEM_WAIT_RELEASE for IDLE only when all three request levels are low. This prevents re-issuing a burst before the cache leaves its load/store state.
- Ignored inputs:
  - A request that rises during a burst is ignored until IDLE.
  - `*_finish` or beats that arrive in a non-matching state are ignored, and the counter does not move.
- Counter width is 10 bits and saturates at 1023 (no wrap).

## Timing
- Request seen at edge n → burst request high from edge n+1.
- Controller read beat at edge m → `DATA_to_cache`, `rd_burst_data_valid` and `rd_cnt_data` all change at edge m+1, together.
- Write path has zero latency: `wr_burst_data_req_in` to `wr_burst_data_req` is combinational. The cache must present `DATA_to_ddr` within the same cycle.
- `*_finish` at edge f → request low and state MEM_WAIT_RELEASE at f+1. Earliest IDLE is f+2.
- Simultaneous `*_finish` and beat: the beat is processed, then the state changes.
- Reset mid-burst: all outputs return to 0 at once. The controller is required to abort on `rd_burst_req`/`wr_burst_req` falling.

## Structure
- Shared package `ap_mem_pkg`:
  - state codes (MEM_WRITE_DATA_STORE=9 is shared with `data_cache`)
  - burst-length constants
- One sub-module, `burst_beat_counter`: preload / increment / saturate, reused by later instruction-cache interfaces.
- Target size is roughly 200 lines.

## Test plan
- Data read at addr 0x800 → `rd_burst_addr`=0x800, len 16. The 16 beats give `rd_cnt_data` 2..17 with `DATA_to_cache` matching one cycle later. State goes 2 → 8 → 0 after the request drops.
- Jump read with beat 0x1234 → `rd_cnt_data`=1, valid=1 and `JMP_ADDR_to_cache`=0x0001234, all on the same edge.
- Store at 0x40000 → `wr_burst_len`=16 and state_interface_module=9. Each `wr_burst_data_req_in` mirrors to `wr_burst_data_req`, and `wr_burst_data_out`=`DATA_to_ddr`.
- Store and data read asserted in the same cycle → the store is granted first. After release, the read is granted.
- Request still high after finish → stays in state 8 with no second burst. Dropping the request returns to IDLE next cycle.
- `rst` low at beat 5 of a data read → all outputs 0 and state IDLE immediately. The next request restarts with counter preload 1.

Source files
------------

// File: rtl/ap_mem_pkg.sv
// Shared memory-interface definitions: state codes decoded by data_cache and burst constants.
package ap_mem_pkg;

  localparam int CNT_WIDTH = 10;

  // Code 9 is decoded directly by data_cache; keep the encoding fixed.
  typedef enum logic [3:0] {
    IDLE                 = 4'd0,
    MEM_READ_DATA        = 4'd2,
    MEM_READ_JMP         = 4'd3,
    MEM_WAIT_RELEASE     = 4'd8,
    MEM_WRITE_DATA_STORE = 4'd9
  } mem_state_e;

  localparam logic [CNT_WIDTH-1:0] JMP_BURST_LEN       = 10'd1;
  localparam logic [CNT_WIDTH-1:0] RD_CNT_PRELOAD_DATA = 10'd1;
  localparam logic [CNT_WIDTH-1:0] RD_CNT_PRELOAD_JMP  = 10'd0;
  localparam logic [CNT_WIDTH-1:0] RD_CNT_PRELOAD_WR   = 10'd0;

endpackage

// File: rtl/ddr_cache_interface_if.sv
// Cache-side and DDR-controller-side signals of the cache/DDR bridge.
interface ddr_cache_interface_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28
);
  // cache side
  logic                      DATA_read_req;
  logic                      DATA_store_req;
  logic                      JMP_ADDR_read_req;
  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr;
  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr;
  logic [DATA_WIDTH-1:0]     DATA_to_ddr;
  logic [DATA_WIDTH-1:0]     DATA_to_cache;
  logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache;
  logic [9:0]                rd_cnt_data;
  logic                      rd_burst_data_valid;
  logic                      wr_burst_data_req;
  logic [3:0]                state_interface_module;
  // controller side
  logic                      rd_burst_req;
  logic                      wr_burst_req;
  logic [9:0]                rd_burst_len;
  logic [9:0]                wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      rd_burst_data_valid_in;
  logic [DATA_WIDTH-1:0]     rd_burst_data_in;
  logic                      rd_burst_finish;
  logic                      wr_burst_finish;
  logic                      wr_burst_data_req_in;
  logic [DATA_WIDTH-1:0]     wr_burst_data_out;

  modport slave (
    input  DATA_read_req, DATA_store_req, JMP_ADDR_read_req,
    input  DATA_read_addr, DATA_write_addr, DATA_to_ddr,
    output DATA_to_cache, JMP_ADDR_to_cache, rd_cnt_data, rd_burst_data_valid,
    output wr_burst_data_req, state_interface_module,
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
    output rd_burst_addr, wr_burst_addr, wr_burst_data_out,
    input  rd_burst_data_valid_in, rd_burst_data_in,
    input  rd_burst_finish, wr_burst_finish, wr_burst_data_req_in
  );

  modport master (
    output DATA_read_req, DATA_store_req, JMP_ADDR_read_req,
    output DATA_read_addr, DATA_write_addr, DATA_to_ddr,
    input  DATA_to_cache, JMP_ADDR_to_cache, rd_cnt_data, rd_burst_data_valid,
    input  wr_burst_data_req, state_interface_module,
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
    input  rd_burst_addr, wr_burst_addr, wr_burst_data_out,
    output rd_burst_data_valid_in, rd_burst_data_in,
    output rd_burst_finish, wr_burst_finish, wr_burst_data_req_in
  );
endinterface

// File: rtl/burst_beat_counter.sv
// Beat counter with preload, increment and saturation at all-ones.
module burst_beat_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preload_i,
  input  logic [WIDTH-1:0] preload_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (preload_i) begin
      cnt_d = preload_val_i;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ddr_cache_interface.sv
// Arbitrates data_cache load/store/jump requests and turns each grant into one DDR burst.
module ddr_cache_interface
  import ap_mem_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int DDR_ADDR_WIDTH   = 28
) (
  input logic                 clk,
  input logic                 rst,
  ddr_cache_interface_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] DATA_BURST_LEN = CNT_WIDTH'(DATA_CACHE_DEPTH);

  mem_state_e                state_q, state_d;
  logic                      rd_req_q, rd_req_d;
  logic                      wr_req_q, wr_req_d;
  logic [CNT_WIDTH-1:0]      rd_len_q, rd_len_d;
  logic [CNT_WIDTH-1:0]      wr_len_q, wr_len_d;
  logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DDR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     data_to_cache_q, data_to_cache_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [DDR_ADDR_WIDTH-1:0] jmp_addr_q, jmp_addr_d;

  logic                      beat_ok;
  logic                      cnt_preload;
  logic [CNT_WIDTH-1:0]      cnt_preload_val;
  logic [CNT_WIDTH-1:0]      rd_cnt;

  // Beats outside a read state are dropped entirely, including the counter.
  assign beat_ok = bus.rd_burst_data_valid_in &&
                   ((state_q == MEM_READ_DATA) || (state_q == MEM_READ_JMP));

  always_comb begin
    state_d         = state_q;
    rd_req_d        = rd_req_q;
    wr_req_d        = wr_req_q;
    rd_len_d        = rd_len_q;
    wr_len_d        = wr_len_q;
    rd_addr_d       = rd_addr_q;
    wr_addr_d       = wr_addr_q;
    jmp_addr_d      = jmp_addr_q;
    cnt_preload     = 1'b0;
    cnt_preload_val = '0;
    rd_valid_d      = beat_ok;
    data_to_cache_d = beat_ok ? bus.rd_burst_data_in : data_to_cache_q;

    unique case (state_q)
      IDLE: begin
        if (bus.DATA_store_req) begin
          wr_addr_d       = bus.DATA_write_addr;
          wr_len_d        = DATA_BURST_LEN;
          wr_req_d        = 1'b1;
          cnt_preload     = 1'b1;
          cnt_preload_val = RD_CNT_PRELOAD_WR;
          state_d         = MEM_WRITE_DATA_STORE;
        end else if (bus.DATA_read_req) begin
          rd_addr_d       = bus.DATA_read_addr;
          rd_len_d        = DATA_BURST_LEN;
          rd_req_d        = 1'b1;
          cnt_preload     = 1'b1;
          cnt_preload_val = RD_CNT_PRELOAD_DATA;
          state_d         = MEM_READ_DATA;
        end else if (bus.JMP_ADDR_read_req) begin
          rd_addr_d       = bus.DATA_read_addr;
          rd_len_d        = JMP_BURST_LEN;
          rd_req_d        = 1'b1;
          cnt_preload     = 1'b1;
          cnt_preload_val = RD_CNT_PRELOAD_JMP;
          jmp_addr_d      = '0;
          state_d         = MEM_READ_JMP;
        end
      end
      MEM_READ_DATA: begin
        if (bus.rd_burst_finish) begin
          rd_req_d = 1'b0;
          state_d  = MEM_WAIT_RELEASE;
        end
      end
      MEM_READ_JMP: begin
        if (beat_ok) begin
          jmp_addr_d = DDR_ADDR_WIDTH'(bus.rd_burst_data_in);
        end
        if (bus.rd_burst_finish) begin
          rd_req_d = 1'b0;
          state_d  = MEM_WAIT_RELEASE;
        end
      end
      MEM_WRITE_DATA_STORE: begin
        if (bus.wr_burst_finish) begin
          wr_req_d = 1'b0;
          state_d  = MEM_WAIT_RELEASE;
        end
      end
      MEM_WAIT_RELEASE: begin
        // Hold until the cache has left its load/store state, else we would re-issue.
        if (!bus.DATA_store_req && !bus.DATA_read_req && !bus.JMP_ADDR_read_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      rd_req_q        <= 1'b0;
      wr_req_q        <= 1'b0;
      rd_len_q        <= '0;
      wr_len_q        <= '0;
      rd_addr_q       <= '0;
      wr_addr_q       <= '0;
      data_to_cache_q <= '0;
      rd_valid_q      <= 1'b0;
      jmp_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      rd_req_q        <= rd_req_d;
      wr_req_q        <= wr_req_d;
      rd_len_q        <= rd_len_d;
      wr_len_q        <= wr_len_d;
      rd_addr_q       <= rd_addr_d;
      wr_addr_q       <= wr_addr_d;
      data_to_cache_q <= data_to_cache_d;
      rd_valid_q      <= rd_valid_d;
      jmp_addr_q      <= jmp_addr_d;
    end
  end

  burst_beat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk           (clk),
    .rst           (rst),
    .preload_i     (cnt_preload),
    .preload_val_i (cnt_preload_val),
    .inc_i         (beat_ok),
    .cnt_o         (rd_cnt)
  );

  assign bus.state_interface_module = state_q;
  assign bus.rd_burst_req           = rd_req_q;
  assign bus.wr_burst_req           = wr_req_q;
  assign bus.rd_burst_len           = rd_len_q;
  assign bus.wr_burst_len           = wr_len_q;
  assign bus.rd_burst_addr          = rd_addr_q;
  assign bus.wr_burst_addr          = wr_addr_q;
  assign bus.DATA_to_cache          = data_to_cache_q;
  assign bus.rd_burst_data_valid    = rd_valid_q;
  assign bus.JMP_ADDR_to_cache      = jmp_addr_q;
  assign bus.rd_cnt_data            = rd_cnt;
  assign bus.wr_burst_data_req      = (state_q == MEM_WRITE_DATA_STORE) && bus.wr_burst_data_req_in;
  assign bus.wr_burst_data_out      = bus.DATA_to_ddr;

endmodule

// File: tb/tb_ddr_cache_interface.sv
// Directed bench for ddr_cache_interface with hand-computed expectations.
module tb_ddr_cache_interface;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  ddr_cache_interface_if #(.DATA_WIDTH(16), .DDR_ADDR_WIDTH(28)) bus ();

  ddr_cache_interface #(
    .DATA_WIDTH       (16),
    .DATA_CACHE_DEPTH (16),
    .DDR_ADDR_WIDTH   (28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b0;
    bus.DATA_read_req          = 1'b0;
    bus.DATA_store_req         = 1'b0;
    bus.JMP_ADDR_read_req      = 1'b0;
    bus.DATA_read_addr         = '0;
    bus.DATA_write_addr        = '0;
    bus.DATA_to_ddr            = '0;
    bus.rd_burst_data_valid_in = 1'b0;
    bus.rd_burst_data_in       = '0;
    bus.rd_burst_finish        = 1'b0;
    bus.wr_burst_finish        = 1'b0;
    bus.wr_burst_data_req_in   = 1'b0;
    tick();
    tick();

    chk("rst_state",  32'(bus.state_interface_module), 32'd0);
    chk("rst_rd_req", 32'(bus.rd_burst_req), 32'd0);
    chk("rst_wr_req", 32'(bus.wr_burst_req), 32'd0);
    chk("rst_cnt",    32'(bus.rd_cnt_data), 32'd0);
    chk("rst_valid",  32'(bus.rd_burst_data_valid), 32'd0);
    chk("rst_rd_len", 32'(bus.rd_burst_len), 32'd0);

    rst = 1'b1;
    tick();

    // data read of 16 beats
    bus.DATA_read_addr = 28'h800;
    bus.DATA_read_req  = 1'b1;
    tick();
    chk("rd_grant_req",   32'(bus.rd_burst_req), 32'd1);
    chk("rd_grant_addr",  32'(bus.rd_burst_addr), 32'h800);
    chk("rd_grant_len",   32'(bus.rd_burst_len), 32'd16);
    chk("rd_grant_state", 32'(bus.state_interface_module), 32'd2);
    chk("rd_grant_cnt",   32'(bus.rd_cnt_data), 32'd1);
    bus.JMP_ADDR_read_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.rd_burst_data_valid_in = 1'b1;
      bus.rd_burst_data_in       = 16'hA000 + 16'(k);
      bus.rd_burst_finish        = (k == 15);
      tick();
      chk("rd_beat_cnt",   32'(bus.rd_cnt_data), 32'(k + 2));
      chk("rd_beat_data",  32'(bus.DATA_to_cache), 32'h0000A000 + 32'(k));
      chk("rd_beat_valid", 32'(bus.rd_burst_data_valid), 32'd1);
    end
    chk("rd_fin_state", 32'(bus.state_interface_module), 32'd8);
    chk("rd_fin_req",   32'(bus.rd_burst_req), 32'd0);
    bus.rd_burst_data_valid_in = 1'b0;
    bus.rd_burst_finish        = 1'b0;
    tick();
    tick();
    chk("wait_hold_state", 32'(bus.state_interface_module), 32'd8);
    chk("wait_no_reburst", 32'(bus.rd_burst_req), 32'd0);
    chk("wait_valid_low",  32'(bus.rd_burst_data_valid), 32'd0);
    bus.DATA_read_req = 1'b0;
    tick();
    chk("wait_jmp_holds", 32'(bus.state_interface_module), 32'd8);
    bus.JMP_ADDR_read_req = 1'b0;
    tick();
    chk("release_idle", 32'(bus.state_interface_module), 32'd0);
    chk("cnt_held",     32'(bus.rd_cnt_data), 32'd17);

    // beat and finish in IDLE are ignored
    bus.rd_burst_data_valid_in = 1'b1;
    bus.rd_burst_finish        = 1'b1;
    tick();
    chk("idle_beat_cnt",   32'(bus.rd_cnt_data), 32'd17);
    chk("idle_beat_valid", 32'(bus.rd_burst_data_valid), 32'd0);
    chk("idle_beat_state", 32'(bus.state_interface_module), 32'd0);
    bus.rd_burst_data_valid_in = 1'b0;
    bus.rd_burst_finish        = 1'b0;

    // jump read
    bus.DATA_read_addr    = 28'h120;
    bus.JMP_ADDR_read_req = 1'b1;
    tick();
    chk("jmp_state", 32'(bus.state_interface_module), 32'd3);
    chk("jmp_len",   32'(bus.rd_burst_len), 32'd1);
    chk("jmp_cnt",   32'(bus.rd_cnt_data), 32'd0);
    chk("jmp_req",   32'(bus.rd_burst_req), 32'd1);
    chk("jmp_addr",  32'(bus.rd_burst_addr), 32'h120);
    bus.rd_burst_data_valid_in = 1'b1;
    bus.rd_burst_data_in       = 16'h1234;
    bus.rd_burst_finish        = 1'b1;
    tick();
    chk("jmp_beat_cnt",   32'(bus.rd_cnt_data), 32'd1);
    chk("jmp_beat_valid", 32'(bus.rd_burst_data_valid), 32'd1);
    chk("jmp_beat_addr",  32'(bus.JMP_ADDR_to_cache), 32'h0001234);
    chk("jmp_fin_state",  32'(bus.state_interface_module), 32'd8);
    bus.rd_burst_data_valid_in = 1'b0;
    bus.rd_burst_finish        = 1'b0;
    bus.rd_burst_data_in       = 16'h5555;
    bus.JMP_ADDR_read_req      = 1'b0;
    tick();
    chk("jmp_idle",      32'(bus.state_interface_module), 32'd0);
    chk("jmp_addr_hold", 32'(bus.JMP_ADDR_to_cache), 32'h0001234);

    // store and read together: store wins
    bus.DATA_write_addr = 28'h40000;
    bus.DATA_read_addr  = 28'h1000;
    bus.DATA_store_req  = 1'b1;
    bus.DATA_read_req   = 1'b1;
    bus.wr_burst_data_req_in = 1'b1;
    #1;
    chk("wr_req_gated_idle", 32'(bus.wr_burst_data_req), 32'd0);
    bus.wr_burst_data_req_in = 1'b0;
    tick();
    chk("st_state",  32'(bus.state_interface_module), 32'd9);
    chk("st_wr_req", 32'(bus.wr_burst_req), 32'd1);
    chk("st_len",    32'(bus.wr_burst_len), 32'd16);
    chk("st_addr",   32'(bus.wr_burst_addr), 32'h40000);
    chk("st_rd_req", 32'(bus.rd_burst_req), 32'd0);
    bus.wr_burst_data_req_in = 1'b1;
    bus.DATA_to_ddr          = 16'hBEEF;
    #1;
    chk("st_dreq_hi", 32'(bus.wr_burst_data_req), 32'd1);
    chk("st_dout_1",  32'(bus.wr_burst_data_out), 32'hBEEF);
    bus.wr_burst_data_req_in = 1'b0;
    bus.DATA_to_ddr          = 16'h0C3A;
    #1;
    chk("st_dreq_lo", 32'(bus.wr_burst_data_req), 32'd0);
    chk("st_dout_2",  32'(bus.wr_burst_data_out), 32'h0C3A);
    bus.rd_burst_finish = 1'b1;
    tick();
    chk("st_ignore_rdfin", 32'(bus.state_interface_module), 32'd9);
    chk("st_req_held",     32'(bus.wr_burst_req), 32'd1);
    bus.rd_burst_finish = 1'b0;
    bus.wr_burst_finish = 1'b1;
    tick();
    chk("st_fin_state", 32'(bus.state_interface_module), 32'd8);
    chk("st_fin_req",   32'(bus.wr_burst_req), 32'd0);
    bus.wr_burst_finish      = 1'b0;
    bus.wr_burst_data_req_in = 1'b1;
    #1;
    chk("st_dreq_wait", 32'(bus.wr_burst_data_req), 32'd0);
    bus.wr_burst_data_req_in = 1'b0;
    bus.DATA_store_req = 1'b0;
    tick();
    chk("st_read_holds_wait", 32'(bus.state_interface_module), 32'd8);
    bus.DATA_read_req = 1'b0;
    tick();
    chk("st_release", 32'(bus.state_interface_module), 32'd0);
    bus.DATA_read_req = 1'b1;
    tick();
    chk("rd2_state", 32'(bus.state_interface_module), 32'd2);
    chk("rd2_addr",  32'(bus.rd_burst_addr), 32'h1000);
    chk("rd2_cnt",   32'(bus.rd_cnt_data), 32'd1);

    // reset at beat 5
    for (int k = 0; k < 5; k++) begin
      bus.rd_burst_data_valid_in = 1'b1;
      bus.rd_burst_data_in       = 16'h7000 + 16'(k);
      tick();
    end
    chk("rd2_cnt_b5", 32'(bus.rd_cnt_data), 32'd6);
    bus.rd_burst_data_valid_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_state", 32'(bus.state_interface_module), 32'd0);
    chk("mrst_req",   32'(bus.rd_burst_req), 32'd0);
    chk("mrst_cnt",   32'(bus.rd_cnt_data), 32'd0);
    chk("mrst_data",  32'(bus.DATA_to_cache), 32'd0);
    chk("mrst_addr",  32'(bus.rd_burst_addr), 32'd0);
    chk("mrst_len",   32'(bus.rd_burst_len), 32'd0);
    chk("mrst_jmp",   32'(bus.JMP_ADDR_to_cache), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.DATA_read_addr = 28'h800;
    tick();
    chk("rst_restart_state", 32'(bus.state_interface_module), 32'd2);
    chk("rst_restart_cnt",   32'(bus.rd_cnt_data), 32'd1);

    // counter saturation
    bus.rd_burst_data_valid_in = 1'b1;
    repeat (1100) tick();
    chk("cnt_saturate", 32'(bus.rd_cnt_data), 32'd1023);
    bus.rd_burst_data_valid_in = 1'b0;
    bus.rd_burst_finish        = 1'b1;
    bus.DATA_read_req          = 1'b0;
    tick();
    bus.rd_burst_finish = 1'b0;
    tick();
    chk("end_idle", 32'(bus.state_interface_module), 32'd0);
    chk("end_cnt",  32'(bus.rd_cnt_data), 32'd1023);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
